// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the MEM-stage core port and an external loader/debug port.
// Optional build macro DMEM_ARB_STATS_EN adds stall_cycles / ext_beats counters.
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_mem_read,
    input  logic              core_mem_write,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [2:0]        core_fun3,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    input  logic [2:0]        ext_fun3,
    output logic              ext_gnt,
    output logic [31:0]       ext_rdata,
    output logic              ext_rvalid,
    output logic [31:0]       dmem_addr,
    output logic              dmem_mem_read,
    output logic              dmem_mem_write,
    output logic [31:0]       dmem_wdata,
    output logic [2:0]        dmem_fun3,
    input  logic [31:0]       dmem_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       ext_beats,
`endif
    output logic              dbg_st,
    output logic [WAIT_W-1:0] dbg_wait_cnt
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } st_t;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    st_t               st, st_n;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
    logic              core_act;
    logic              wait_hit;

    assign core_act     = core_mem_read | core_mem_write;
    assign wait_hit     = (wait_cnt == MAX_WAIT_C);
    assign dbg_st       = st;
    assign dbg_wait_cnt = wait_cnt;

    // Handshake: ext_req is held with stable ext_* fields until a cycle with
    // ext_gnt=1, which is the cycle the beat is performed on DMEM. Read data
    // follows one cycle later as a single-cycle ext_rvalid pulse.
    always_comb begin
        ext_gnt = 1'b0;
        if (!rst) begin
            case (st)
                ARB:     ext_gnt = ext_req & (~core_act | wait_hit);
                LOCK:    ext_gnt = ext_req;
                default: ext_gnt = 1'b0;
            endcase
        end
    end

    assign core_stall = core_act & ext_gnt;
    assign core_rdata = ext_gnt ? 32'd0 : dmem_rdata;

    always_comb begin
        dmem_addr      = core_addr;
        dmem_mem_read  = core_mem_read;
        dmem_mem_write = core_mem_write & ~rst;
        dmem_wdata     = core_wdata;
        dmem_fun3      = core_fun3;
        if (ext_gnt) begin
            dmem_addr      = ext_addr;
            dmem_mem_read  = ~ext_we;
            dmem_mem_write = ext_we;
            dmem_wdata     = ext_wdata;
            dmem_fun3      = ext_fun3;
        end
    end

    always_comb begin
        st_n       = st;
        wait_cnt_n = wait_cnt;
        case (st)
            ARB: begin
                if (ext_gnt & ext_lock) st_n = LOCK;
            end
            LOCK: begin
                if ((ext_gnt & ~ext_lock) | ~ext_req) st_n = ARB;
            end
            default: st_n = ARB;
        endcase
        // Counts cycles ext has been refused in ARB; saturates so the forced grant holds.
        if (ext_gnt | ~ext_req | (st == LOCK)) wait_cnt_n = '0;
        else if (!wait_hit)                     wait_cnt_n = wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ARB;
            wait_cnt   <= '0;
            ext_rdata  <= 32'd0;
            ext_rvalid <= 1'b0;
        end else begin
            st       <= st_n;
            wait_cnt <= wait_cnt_n;
            if (ext_gnt & ~ext_we) begin
                ext_rdata  <= dmem_rdata;
                ext_rvalid <= 1'b1;
            end else begin
                ext_rvalid <= 1'b0;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            ext_beats    <= 32'd0;
        end else begin
            if (core_stall) stall_cycles <= stall_cycles + 32'd1;
            if (ext_gnt)    ext_beats    <= ext_beats + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory (DMEM) between two requesters: the pipeline MEM stage (core) and an external loader/debug port (ext). The core has default priority. A bounded-wait counter guarantees ext progress, and a lock mode gives ext exclusive multi-beat access. Sits between the MEM-stage datapath (after the store-data forwarding mux) and the DMEM instance.

Parameters:
MAX_WAIT, 4, cycles ext may wait while core is active before ext is forced a grant (1..255)
WAIT_W, 8, width of the wait counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
core_mem_read  input  1  MEM-stage load request
core_mem_write  input  1  MEM-stage store request
core_addr  input  32  MEM-stage address (alu result)
core_wdata  input  32  MEM-stage store data (post-forwarding)
core_fun3  input  3  MEM-stage access size/sign control
core_rdata  output  32  load data to MEM/WB
core_stall  output  1  core access not performed this cycle; hold pipeline
ext_req  input  1  ext access request
ext_we  input  1  ext access is a write
ext_lock  input  1  keep exclusive grant after this beat
ext_addr  input  32  ext address
ext_wdata  input  32  ext store data
ext_fun3  input  3  ext access size/sign control
ext_gnt  output  1  ext access performed this cycle
ext_rdata  output  32  registered ext load data
ext_rvalid  output  1  ext_rdata valid (one-cycle pulse)
dmem_addr  output  32  to DMEM addr
dmem_mem_read  output  1  to DMEM MemRead
dmem_mem_write  output  1  to DMEM MemWrite
dmem_wdata  output  32  to DMEM Write_Data
dmem_fun3  output  3  to DMEM control
dmem_rdata  input  32  from DMEM Read_Data (combinational read)

Behaviour:
- DMEM contract: write on rising edge when dmem_mem_write=1; read data is combinational from address/control.
- Registered state: st (ARB, LOCK), wait_cnt[WAIT_W-1:0], ext_rdata, ext_rvalid. Reset: st=ARB, wait_cnt=0, ext_rdata=0, ext_rvalid=0.
- core_act = core_mem_read | core_mem_write.
- Grant, decided combinationally each cycle:
  - ARB: ext_gnt = ext_req & (~core_act | wait_cnt==MAX_WAIT).
  - LOCK: ext_gnt = ext_req.
- core_stall = core_act & ext_gnt. The core holds its request while stalled.
- While rst=1: ext_gnt=0, core_stall=0, dmem_mem_write=0.
- DMEM mux:
  - ext_gnt=1: dmem_* come from ext_*, with dmem_mem_read=~ext_we and dmem_mem_write=ext_we.
  - Otherwise dmem_* come from core_*.
  - core_rdata = dmem_rdata when ext_gnt=0, else 0.
- wait_cnt:
  - Cleared when ext_gnt, ~ext_req, or st=LOCK.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Forced grant therefore occurs on the (MAX_WAIT+1)th cycle of continuous core contention.
- ext read: on a cycle with ext_gnt & ~ext_we, ext_rdata<=dmem_rdata and ext_rvalid<=1 next cycle. Otherwise ext_rvalid<=0 and ext_rdata holds.
- FSM:
  - ARB->LOCK on ext_gnt & ext_lock.
  - LOCK->ARB on (ext_gnt & ~ext_lock) or ~ext_req.
  - In LOCK, core is stalled on every cycle with core_act & ext_req.
- Simultaneous core and ext writes to the same address: only the granted side writes, with no merging.
- Reset mid-lock: returns to ARB and any pending ext_rvalid is dropped.

Optional Feature:
DMEM_ARB_STATS_EN:
- Defined: adds output ports stall_cycles[31:0] (counts cycles with core_stall=1) and ext_beats[31:0] (counts cycles with ext_gnt=1). Both are zero on rst and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Core load only, addr=0x10, DMEM[0x10]=0xDEADBEEF -> core_rdata=0xDEADBEEF same cycle; core_stall=0; ext_gnt=0.
- Core idle, ext write 0x20<=0x12345678 then ext read 0x20 -> ext_gnt=1 both cycles; ext_rvalid=1 one cycle after the read with ext_rdata=0x12345678.
- Core active every cycle, ext_req held, MAX_WAIT=4 -> ext_gnt=0 for 4 cycles, ext_gnt=1 and core_stall=1 on the 5th; wait_cnt returns to 0.
- ext_lock=1 for 3 beats then ext_lock=0 on the 4th, core active throughout -> core_stall=1 for all 4 beats; st=ARB after the 4th; core resumes next cycle.
- Assert rst during LOCK with a pending ext read -> next cycle st=ARB, ext_rvalid=0, ext_rdata=0, no DMEM write on the reset cycle.
- With DMEM_ARB_STATS_EN, run the forced-grant scenario -> stall_cycles=1, ext_beats=1.
